// File: rtl/datamem_pkg.sv
// datamem_pkg: shared widths and access-type encoding for the data memory
package datamem_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;
endpackage

// File: rtl/datamem.sv
// datamem: word-addressed 32-bit data memory for the load/store path
//   clk       rising-edge clock, one access per edge
//   rst       asynchronous active-high reset, clears array and dataOut
//   Ina       word address, only the low ADDR_W bits index the array
//   Inb       write data
//   enable    1 = access this cycle, 0 = idle
//   readwrite 0 = load word, 1 = store word
//   dataOut   registered read data (write-through on stores)
module datamem
    import datamem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       Ina,
    input  logic [DATA_W-1:0] Inb,
    input  logic              enable,
    input  logic              readwrite,
    output logic [DATA_W-1:0] dataOut
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              unused_hi;

    // Upper address bits alias onto the same word; they are deliberately dropped.
    assign idx       = Ina[ADDR_W-1:0];
    assign unused_hi = ^Ina[31:ADDR_W];

    // Register array rather than inferred RAM so the whole contents clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dataOut <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (enable) begin
            if (readwrite == MEM_WRITE) begin
                mem[idx] <= Inb;
                dataOut  <= Inb;
            end else begin
                dataOut <= mem[idx];
            end
        end
    end
endmodule

// File: tb/tb_datamem.sv
// tb_datamem: directed scoreboard bench for datamem
module tb_datamem;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] Ina = '0;
    logic [31:0] Inb = '0;
    logic        enable = 1'b0;
    logic        readwrite = 1'b0;
    logic [31:0] dataOut;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q [$];
    string       tag_q [$];

    datamem dut (
        .clk(clk),
        .rst(rst),
        .Ina(Ina),
        .Inb(Inb),
        .enable(enable),
        .readwrite(readwrite),
        .dataOut(dataOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic en, input logic rw, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp, input string tag);
        @(negedge clk);
        enable = en;
        readwrite = rw;
        Ina = a;
        Inb = d;
        sb_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check(tag_q.pop_front(), dataOut, sb_q.pop_front());
        enable = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        check("rst_hold", dataOut, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        op(1, 0, 32'd1, 32'h0, 32'h0, "rd_after_rst_1");
        for (int i = 0; i <= 10; i++) op(1, 0, i, 32'h0, 32'h0, "rd_clear");

        op(1, 1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "wr1_through");
        op(1, 0, 32'd1, 32'h0, 32'hFFFFFFFF, "rd1");
        op(1, 0, 32'd0, 32'h0, 32'h0, "rd0_untouched");
        op(1, 0, 32'd2, 32'h0, 32'h0, "rd2_untouched");

        op(1, 0, 32'd1, 32'h0, 32'hFFFFFFFF, "rd1_again");
        op(0, 1, 32'd3, 32'hDEADBEEF, 32'hFFFFFFFF, "idle_hold");
        op(0, 0, 32'd0, 32'h0, 32'hFFFFFFFF, "idle_hold_rd");
        op(1, 0, 32'd3, 32'h0, 32'h0, "rd3_no_write");

        op(1, 1, 32'h0001_0005, 32'h12345678, 32'h12345678, "wr_alias");
        op(1, 0, 32'd0, 32'h0, 32'h0, "rd0_clear_out");
        op(1, 0, 32'd5, 32'h0, 32'h12345678, "rd5_alias");
        op(1, 0, 32'hABCD_0005, 32'h0, 32'h12345678, "rd5_alias_hi");

        op(1, 1, 32'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, "wr7");
        // reset pulse lands mid-cycle while a write to 9 is pending
        @(negedge clk);
        enable = 1'b1;
        readwrite = 1'b1;
        Ina = 32'd9;
        Inb = 32'hCAFEF00D;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out", dataOut, 32'h0);
        @(posedge clk);
        #1;
        check("rst_beats_access", dataOut, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        op(1, 0, 32'd7, 32'h0, 32'h0, "rd7_after_rst");
        op(1, 0, 32'd9, 32'h0, 32'h0, "rd9_aborted");
        op(1, 0, 32'd1, 32'h0, 32'h0, "rd1_after_rst");
        op(1, 0, 32'd5, 32'h0, 32'h0, "rd5_after_rst");

        op(1, 1, 32'h0000FFFF, 32'h0BADF00D, 32'h0BADF00D, "wr_top");
        op(1, 0, 32'd0, 32'h0, 32'h0, "rd0_after_top");
        op(1, 0, 32'h0000FFFF, 32'h0, 32'h0BADF00D, "rd_top");
        op(1, 0, 32'd65534, 32'h0, 32'h0, "rd_top_minus1");

        op(1, 1, 32'd4, 32'h11112222, 32'h11112222, "wr4");
        op(1, 1, 32'd4, 32'h33334444, 32'h33334444, "wr4_over");
        op(1, 0, 32'd4, 32'h0, 32'h33334444, "rd4_latest");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
